// File: rtl/mux21_arbiter.sv
// -----------------------------------------------------------------------------
// mux21_arbiter
//   Two-requester round-robin arbiter that acts as the only controller of a
//   shared 2:1 datapath mux (mux21). Requesters A and B each present packets
//   over a valid/ready/last handshake. The arbiter grants one whole packet at
//   a time, drives the mux select s, and forwards the accepted beats through a
//   one-entry registered output stage.
//
//   Select convention follows mux21: s = 0 selects A, s = 1 selects B.
//
// Parameters
//   WIDTH    data width of a_data, b_data and m_data
//
// Ports
//   clk      single clock; all state updates on the rising edge
//   reset    synchronous, active-high reset
//   a_valid  requester A beat valid
//   a_data   requester A beat data
//   a_last   requester A final beat of the packet
//   a_ready  A beat accepted when a_valid & a_ready
//   b_valid  requester B beat valid
//   b_data   requester B beat data
//   b_last   requester B final beat of the packet
//   b_ready  B beat accepted when b_valid & b_ready
//   m_valid  output beat valid (registered)
//   m_data   output beat data (registered)
//   m_last   output last flag (registered)
//   m_ready  downstream accepts when m_valid & m_ready
//   s        mux select, 0 = A granted, 1 = B granted (registered)
//   busy     high while a packet grant is open
// -----------------------------------------------------------------------------
module mux21_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             s,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             pri_r;         // 0: A wins a tie, 1: B wins a tie
  logic             pri_next_s;
  logic             s_r;
  logic             s_next_s;

  logic             m_valid_r;
  logic [WIDTH-1:0] m_data_r;
  logic             m_last_r;

  logic             slot_free_s;   // output stage can take a beat this cycle
  logic             a_ready_s;
  logic             b_ready_s;
  logic             a_acc_s;
  logic             b_acc_s;
  logic             acc_s;
  logic [WIDTH-1:0] acc_data_s;
  logic             acc_last_s;

  // The output register is free when empty or being drained this cycle.
  assign slot_free_s = ~m_valid_r | m_ready;

  // Ready generation: only the granted port may be accepted. Readies are
  // held low while reset is asserted so nothing is accepted in that cycle.
  always_comb begin
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    case (state_r)
      GRANT_A: begin
        a_ready_s = slot_free_s & ~reset;
      end
      GRANT_B: begin
        b_ready_s = slot_free_s & ~reset;
      end
      IDLE: begin
        a_ready_s = 1'b0;
        b_ready_s = 1'b0;
      end
      default: begin
        a_ready_s = 1'b0;
        b_ready_s = 1'b0;
      end
    endcase
  end

  assign a_acc_s = a_valid & a_ready_s;
  assign b_acc_s = b_valid & b_ready_s;
  assign acc_s   = a_acc_s | b_acc_s;

  // Steer the accepted beat into the output stage; at most one port is
  // ever accepted in a cycle.
  always_comb begin
    acc_data_s = {WIDTH{1'b0}};
    acc_last_s = 1'b0;
    if (a_acc_s) begin
      acc_data_s = a_data;
      acc_last_s = a_last;
    end else if (b_acc_s) begin
      acc_data_s = b_data;
      acc_last_s = b_last;
    end else begin
      acc_data_s = {WIDTH{1'b0}};
      acc_last_s = 1'b0;
    end
  end

  // Grant FSM next-state, round-robin priority and mux select update.
  // A finished packet always returns through IDLE, so back-to-back packets
  // from different ports are separated by one idle cycle.
  always_comb begin
    state_next_s = state_r;
    pri_next_s   = pri_r;
    s_next_s     = s_r;
    case (state_r)
      IDLE: begin
        if (a_valid && b_valid) begin
          if (pri_r) begin
            state_next_s = GRANT_B;
            s_next_s     = 1'b1;
          end else begin
            state_next_s = GRANT_A;
            s_next_s     = 1'b0;
          end
        end else if (a_valid) begin
          state_next_s = GRANT_A;
          s_next_s     = 1'b0;
        end else if (b_valid) begin
          state_next_s = GRANT_B;
          s_next_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      GRANT_A: begin
        // Grant is held until the last beat is taken, even if a_valid drops.
        if (a_acc_s && a_last) begin
          state_next_s = IDLE;
          pri_next_s   = 1'b1;
        end else begin
          state_next_s = GRANT_A;
        end
      end
      GRANT_B: begin
        if (b_acc_s && b_last) begin
          state_next_s = IDLE;
          pri_next_s   = 1'b0;
        end else begin
          state_next_s = GRANT_B;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM, priority and select registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      pri_r   <= 1'b0;
      s_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pri_r   <= pri_next_s;
      s_r     <= s_next_s;
    end
  end

  // One-entry output stage: load on accept, empty when drained with no
  // refill, otherwise hold so back-pressured data stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_r <= 1'b0;
      m_data_r  <= {WIDTH{1'b0}};
      m_last_r  <= 1'b0;
    end else if (acc_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= acc_data_s;
      m_last_r  <= acc_last_s;
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  assign a_ready = a_ready_s;
  assign b_ready = b_ready_s;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_last  = m_last_r;
  assign s       = s_r;
  assign busy    = (state_r == GRANT_A) || (state_r == GRANT_B);

endmodule

// File: tb/tb_mux21_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux21_arbiter
//   Directed bench for mux21_arbiter. Inputs change and outputs are sampled
//   shortly after the falling clock edge; expected values are hand-derived
//   cycle by cycle.
// -----------------------------------------------------------------------------
module tb_mux21_arbiter;

  logic       clk;
  logic       reset;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_last;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_last;
  logic       b_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       s;
  logic       busy;

  int total_checks;
  int bad_checks;

  mux21_arbiter #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_ready (m_ready),
    .s       (s),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge (inputs are changed here).
  task automatic cyc();
    @(negedge clk);
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic quiet_inputs();
    a_valid = 1'b0; a_data = 8'h00; a_last = 1'b0;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    quiet_inputs();
    m_ready = 1'b1;
    repeat (n) cyc();
    reset = 1'b0;
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    reset   = 1'b1;
    m_ready = 1'b1;
    quiet_inputs();

    // ---- 1: reset held for 3 cycles --------------------------------------
    repeat (3) cyc();
    settle();
    check_val("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_val("rst_m_data",  {24'd0, m_data},  32'd0);
    check_val("rst_a_ready", {31'd0, a_ready}, 32'd0);
    check_val("rst_b_ready", {31'd0, b_ready}, 32'd0);
    check_val("rst_s",       {31'd0, s},       32'd0);
    check_val("rst_busy",    {31'd0, busy},    32'd0);
    reset = 1'b0;

    // ---- 2: A packet 11,22,33(last) at full throughput -------------------
    cyc();
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0; m_ready = 1'b1;
    settle();
    check_val("t2_idle_a_ready", {31'd0, a_ready}, 32'd0);
    cyc(); settle();
    check_val("t2_busy",     {31'd0, busy},    32'd1);
    check_val("t2_a_ready",  {31'd0, a_ready}, 32'd1);
    check_val("t2_m_valid1", {31'd0, m_valid}, 32'd0);
    cyc();
    a_data = 8'h22;
    settle();
    check_val("t2_m_valid2", {31'd0, m_valid}, 32'd1);
    check_val("t2_data0",    {24'd0, m_data},  32'h11);
    check_val("t2_last0",    {31'd0, m_last},  32'd0);
    cyc();
    a_data = 8'h33; a_last = 1'b1;
    settle();
    check_val("t2_data1", {24'd0, m_data}, 32'h22);
    check_val("t2_last1", {31'd0, m_last}, 32'd0);
    cyc();
    quiet_inputs();
    settle();
    check_val("t2_data2", {24'd0, m_data}, 32'h33);
    check_val("t2_last2", {31'd0, m_last}, 32'd1);
    check_val("t2_s",     {31'd0, s},      32'd0);
    check_val("t2_idle",  {31'd0, busy},   32'd0);
    cyc(); settle();
    check_val("t2_drained", {31'd0, m_valid}, 32'd0);

    // ---- 3: A and B contend with single-beat packets ---------------------
    do_reset(2);
    a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'hB1; b_last = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cyc(); settle();
      check_val($sformatf("t3_s_%0d", n), {31'd0, s}, ((n - 1) / 2) % 2);
      if (n % 2 == 0) begin
        check_val($sformatf("t3_mv_%0d", n), {31'd0, m_valid}, 32'd1);
        check_val($sformatf("t3_md_%0d", n), {24'd0, m_data},
                  ((n / 2) % 2 == 1) ? 32'hA1 : 32'hB1);
      end else begin
        check_val($sformatf("t3_mv_%0d", n), {31'd0, m_valid}, 32'd0);
      end
    end
    quiet_inputs();
    repeat (2) cyc();

    // ---- 4: back-pressure after the first beat --------------------------
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0; m_ready = 1'b1;
    cyc(); settle();
    check_val("t4_a_ready0", {31'd0, a_ready}, 32'd1);
    cyc();
    a_data = 8'h22; m_ready = 1'b0;
    settle();
    check_val("t4_first", {24'd0, m_data}, 32'h11);
    check_val("t4_bp_ready_0", {31'd0, a_ready}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); settle();
      check_val($sformatf("t4_hold_mv_%0d", k), {31'd0, m_valid}, 32'd1);
      check_val($sformatf("t4_hold_md_%0d", k), {24'd0, m_data}, 32'h11);
      check_val($sformatf("t4_bp_ready_%0d", k), {31'd0, a_ready}, 32'd0);
    end
    cyc();
    m_ready = 1'b1;
    settle();
    check_val("t4_release_ready", {31'd0, a_ready}, 32'd1);
    check_val("t4_release_data",  {24'd0, m_data},  32'h11);
    cyc();
    a_data = 8'h33; a_last = 1'b1;
    settle();
    check_val("t4_second", {24'd0, m_data}, 32'h22);
    cyc();
    quiet_inputs();
    settle();
    check_val("t4_third", {24'd0, m_data}, 32'h33);
    check_val("t4_third_last", {31'd0, m_last}, 32'd1);
    cyc(); settle();
    check_val("t4_no_dup", {31'd0, m_valid}, 32'd0);

    // ---- 5: A requests while B has a packet open -------------------------
    b_valid = 1'b1; b_data = 8'hB1; b_last = 1'b0;
    cyc(); settle();
    check_val("t5_s_b", {31'd0, s}, 32'd1);
    cyc();
    a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b1;
    b_data = 8'hB2; b_last = 1'b1;
    settle();
    check_val("t5_b1",      {24'd0, m_data},  32'hB1);
    check_val("t5_a_block", {31'd0, a_ready}, 32'd0);
    check_val("t5_b_ready", {31'd0, b_ready}, 32'd1);
    cyc();
    b_valid = 1'b0;
    settle();
    check_val("t5_b2",       {24'd0, m_data},  32'hB2);
    check_val("t5_b2_last",  {31'd0, m_last},  32'd1);
    check_val("t5_bubble",   {31'd0, busy},    32'd0);
    check_val("t5_a_block2", {31'd0, a_ready}, 32'd0);
    cyc(); settle();
    check_val("t5_a_grant", {31'd0, busy},    32'd1);
    check_val("t5_s_a",     {31'd0, s},       32'd0);
    check_val("t5_a_ready", {31'd0, a_ready}, 32'd1);
    cyc();
    quiet_inputs();
    settle();
    check_val("t5_a1", {24'd0, m_data}, 32'hA1);
    cyc();

    // ---- 6: reset during A beat 2, then B-only request -------------------
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0;
    cyc();
    cyc();
    a_data = 8'h22; reset = 1'b1;
    settle();
    check_val("t6_pre_data", {24'd0, m_data}, 32'h11);
    cyc();
    reset = 1'b0;
    quiet_inputs();
    b_valid = 1'b1; b_data = 8'hB1; b_last = 1'b1;
    settle();
    check_val("t6_m_valid", {31'd0, m_valid}, 32'd0);
    check_val("t6_s",       {31'd0, s},       32'd0);
    check_val("t6_busy",    {31'd0, busy},    32'd0);
    check_val("t6_m_data",  {24'd0, m_data},  32'd0);
    cyc(); settle();
    check_val("t6_b_grant", {31'd0, s},       32'd1);
    check_val("t6_b_ready", {31'd0, b_ready}, 32'd1);
    cyc();
    quiet_inputs();
    settle();
    check_val("t6_b_mv",   {31'd0, m_valid}, 32'd1);
    check_val("t6_b_data", {24'd0, m_data},  32'hB1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
